// File: rtl/periph_pkg.sv
// periph_pkg: register word offsets, TCON bit positions and timer write-enable bundle.
package periph_pkg;
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } timer_we_t;
endpackage

// File: rtl/periph_timer.sv
// periph_timer: reloading up-counter with sticky overflow status and registered interrupt.
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  timer_we_t   we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic        ovf;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  always_comb begin
    ovf       = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    tl_next   = we.tl ? wdata : ovf ? th : tcon[TCON_EN] ? tl + 32'd1 : tl;
    tcon_next = tcon;
    if (ovf && tcon[TCON_IE]) tcon_next[TCON_ST] = 1'b1;
    if (we.tcon) tcon_next = wdata[2:0];
  end
  // irq is registered from the next TCON value so it never glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      th   <= we.th ? wdata : th;
      tl   <= tl_next;
      tcon <= tcon_next;
      irq  <= tcon_next[TCON_IE] & tcon_next[TCON_ST];
    end
  end
endmodule

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, seven-segment and free-running systick window.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQOut,
  output logic [7:0]  leds,
  output logic [11:0] digits
);
  logic        hit;
  logic        wr;
  logic [2:0]  off;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic        unused_byte_sel;
  timer_we_t   we;
  assign hit             = Address[31:5] == BASE_ADDR[31:5];
  assign off             = Address[4:2];
  assign wr              = MemWrite && hit;
  assign unused_byte_sel = ^Address[1:0];
  assign we              = '{th: wr && off == OFF_TH, tl: wr && off == OFF_TL, tcon: wr && off == OFF_TCON};
  periph_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wdata (WriteData),
    .th    (th),
    .tl    (tl),
    .tcon  (tcon),
    .irq   (IRQOut)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      leds    <= (wr && off == OFF_LED) ? WriteData[7:0] : leds;
      digits  <= (wr && off == OFF_DIGI) ? WriteData[11:0] : digits;
      systick <= systick + 32'd1;
    end
  end
  always_comb begin
    ReadData = !(MemRead && hit)    ? 32'h0 :
               off == OFF_TH      ? th :
               off == OFF_TL      ? tl :
               off == OFF_TCON    ? {29'h0, tcon} :
               off == OFF_LED     ? {24'h0, leds} :
               off == OFF_DIGI    ? {20'h0, digits} :
               off == OFF_SYSTICK ? systick : 32'h0;
  end
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed and random bus traffic scored against a register-level reference model.
module tb_peripheral_bus;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        IRQOut;
  logic [7:0]  leds;
  logic [11:0] digits;
  always #5 clk = ~clk;
  peripheral_bus #(.BASE_ADDR(BASE)) dut (
    .reset     (reset),
    .clk       (clk),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .IRQOut    (IRQOut),
    .leds      (leds),
    .digits    (digits)
  );
  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_th, m_tl, m_sys;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  bit known = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'h0, m_tcon};
      3'd3: return {24'h0, m_led};
      3'd4: return {20'h0, m_digi};
      3'd5: return m_sys;
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_step(bit rst, bit wr, logic [31:0] a, logic [31:0] wd);
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    if (rst) begin
      {m_th, m_tl, m_sys, m_tcon, m_led, m_digi} = '0;
      known = 1;
      return;
    end
    n_tl = m_tl;
    n_tcon = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        if (m_tcon[1]) n_tcon[2] = 1'b1;
      end else n_tl = m_tl + 1;
    end
    m_sys = m_sys + 1;
    if (wr && a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: m_th = wd;
        3'd1: n_tl = wd;
        3'd2: n_tcon = wd[2:0];
        3'd3: m_led = wd[7:0];
        3'd4: m_digi = wd[11:0];
        default: ;
      endcase
    end
    m_tl = n_tl;
    m_tcon = n_tcon;
  endtask
  task automatic cycle(bit rst, bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst;
    MemRead = rd;
    MemWrite = wr;
    Address = a;
    WriteData = wd;
    if (known) begin
      x.rdata = rd ? m_read(a) : 32'h0;
      x.leds = m_led;
      x.digits = m_digi;
      x.irq = m_tcon[1] & m_tcon[2];
      q.push_back(x);
    end
    model_step(rst, wr, a, wd);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ReadData", ReadData, e.rdata);
      chk("leds", {24'h0, leds}, {24'h0, e.leds});
      chk("digits", {20'h0, digits}, {20'h0, e.digits});
      chk("IRQOut", {31'h0, IRQOut}, {31'h0, e.irq});
    end
  end
  initial begin
    logic [31:0] a, wd, r;
    cycle(1, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, BASE + 32'h14, 0);
    cycle(0, 0, 1, BASE + 32'h00, 32'hFFFF_FFFC);
    cycle(0, 0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
    cycle(0, 0, 1, BASE + 32'h08, 32'h3);
    repeat (3) cycle(0, 1, 0, BASE + 32'h04, 0);
    cycle(0, 1, 0, BASE + 32'h08, 0);
    cycle(0, 0, 1, BASE + 32'h08, 32'h0);
    cycle(0, 0, 1, BASE + 32'h00, 32'hFFFF_FFFF);
    cycle(0, 0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
    cycle(0, 0, 1, BASE + 32'h08, 32'h3);
    cycle(0, 1, 0, BASE + 32'h08, 0);
    cycle(0, 1, 1, BASE + 32'h08, 32'h3);
    cycle(0, 1, 0, BASE + 32'h08, 0);
    cycle(0, 0, 1, BASE + 32'h0C, 32'h1234_56A5);
    cycle(0, 0, 1, BASE + 32'h10, 32'hFFFF_F3C7);
    cycle(0, 1, 1, BASE + 32'h0D, 32'h0000_005A);
    cycle(0, 1, 0, BASE + 32'h0C, 0);
    cycle(0, 0, 1, BASE + 32'h20, 32'hFFFF_FFFF);
    cycle(0, 0, 1, BASE + 32'h18, 32'hFFFF_FFFF);
    cycle(0, 0, 1, BASE + 32'h14, 32'h0);
    cycle(0, 1, 0, BASE + 32'h20, 0);
    cycle(0, 1, 0, BASE + 32'h18, 0);
    cycle(0, 1, 0, BASE + 32'h1C, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, BASE + 32'(i * 4), 0);
    cycle(0, 0, 1, BASE + 32'h04, 32'hFFFF_FFF0);
    cycle(0, 0, 1, BASE + 32'h08, 32'h7);
    repeat (3) cycle(0, 1, 0, BASE + 32'h04, 0);
    cycle(1, 0, 1, BASE + 32'h0C, 32'hFF);
    repeat (3) cycle(0, 1, 0, BASE + 32'h04, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, BASE + 32'(i * 4), 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      a = (r[2:0] == 3'd0) ? $urandom : BASE;
      a[4:0] = r[7:3];
      wd = (r[9:8] == 2'd0) ? (32'hFFFF_FFF0 | 32'(r[13:10])) : $urandom;
      cycle(r[31:25] == 7'd0, r[16], r[17] & r[18], a, wd);
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
